// File: rtl/icap_pkg.sv
// rtl/icap_pkg.sv - ICAP command words, Spartan-6 register addresses and reader state encoding
package icap_pkg;

    localparam logic [15:0] SYNC_W1     = 16'hAA99;
    localparam logic [15:0] SYNC_W2     = 16'h5566;
    localparam logic [15:0] NOOP        = 16'h2000;
    localparam logic [15:0] WR_CMD_HDR  = 16'h30A1;
    localparam logic [15:0] CMD_DESYNC  = 16'h000D;
    localparam logic [15:0] CMD_REBOOT  = 16'h000E;
    localparam logic [15:0] RD_HDR_BASE = 16'h2801;
    localparam logic [15:0] IDLE_WORD   = 16'hFFFF;

    localparam logic [5:0] REG_STAT     = 6'h08;
    localparam logic [5:0] REG_IDCODE   = 6'h0E;
    localparam logic [5:0] REG_GENERAL1 = 6'h13;
    localparam logic [5:0] REG_GENERAL2 = 6'h14;
    localparam logic [5:0] REG_GENERAL3 = 6'h15;
    localparam logic [5:0] REG_GENERAL4 = 6'h16;
    localparam logic [5:0] REG_GENERAL5 = 6'h17;
    localparam logic [5:0] REG_MODE     = 6'h18;
    localparam logic [5:0] REG_BOOTSTS  = 6'h20;

    // Encoding is sequential so straight-line states advance by +1.
    localparam logic [4:0] ST_IDLE   = 5'd0;
    localparam logic [4:0] ST_SYNC0  = 5'd1;
    localparam logic [4:0] ST_SYNC1  = 5'd2;
    localparam logic [4:0] ST_NOP0   = 5'd3;
    localparam logic [4:0] ST_RDHDR  = 5'd4;
    localparam logic [4:0] ST_NOP1   = 5'd5;
    localparam logic [4:0] ST_NOP2   = 5'd6;
    localparam logic [4:0] ST_TURN_A = 5'd7;
    localparam logic [4:0] ST_TURN_B = 5'd8;
    localparam logic [4:0] ST_RD     = 5'd9;
    localparam logic [4:0] ST_TURN_C = 5'd10;
    localparam logic [4:0] ST_TURN_D = 5'd11;
    localparam logic [4:0] ST_DSY_H  = 5'd12;
    localparam logic [4:0] ST_DSY_L  = 5'd13;
    localparam logic [4:0] ST_NOP3   = 5'd14;
    localparam logic [4:0] ST_NOP4   = 5'd15;
    localparam logic [4:0] ST_FIN    = 5'd16;

    function automatic logic [15:0] rd_hdr(input logic [5:0] addr);
        return RD_HDR_BASE | {5'b0, addr, 5'b0};
    endfunction

endpackage

// File: rtl/icap_bitswap.sv
// rtl/icap_bitswap.sv - bit reversal within each byte of a 16-bit ICAP word
module icap_bitswap (
    input  logic [15:0] din,
    output logic [15:0] dout
);

    always_comb begin
        dout = '0;
        for (int i = 0; i < 8; i++) begin
            dout[i]     = din[7 - i];
            dout[8 + i] = din[15 - i];
        end
    end

endmodule

// File: rtl/icap_reg_reader.sv
// rtl/icap_reg_reader.sv - reads one configuration register through ICAP, then desyncs
module icap_reg_reader
    import icap_pkg::*;
#(
    parameter int RD_LAT  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [5:0]  REG_ADDR,
    output logic        BUSY,
    output logic        DONE,
    output logic        TIMEOUT_ERR,
    output logic [15:0] DATA,
    output logic        ICAP_CE,
    output logic        ICAP_WRITE,
    output logic [15:0] ICAP_I,
    input  logic [15:0] ICAP_O,
    input  logic        ICAP_BUSY
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] RD_LAT_C  = CW'(RD_LAT);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    logic [4:0]    state_q, state_d;
    logic [5:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   data_q, data_d;
    logic          terr_q, terr_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          ce_q, ce_d;
    logic          wr_q, wr_d;
    logic [15:0]   word_q, word_d;
    logic [15:0]   rd_word;

    icap_bitswap u_swap_o (.din(ICAP_O), .dout(rd_word));
    icap_bitswap u_swap_i (.din(word_q), .dout(ICAP_I));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        terr_d  = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    addr_d  = REG_ADDR;
                    terr_d  = 1'b0;
                    state_d = ST_SYNC0;
                end
            end
            ST_SYNC0, ST_SYNC1, ST_NOP0, ST_RDHDR, ST_NOP1, ST_NOP2, ST_TURN_A,
            ST_TURN_C, ST_TURN_D, ST_DSY_H, ST_DSY_L, ST_NOP3, ST_NOP4:
                state_d = state_q + 5'd1;
            ST_TURN_B: begin
                cnt_d   = '0;
                state_d = ST_RD;
            end
            ST_RD: begin
                // Capture is checked first so it wins on the final timeout cycle.
                if (cnt_q >= RD_LAT_C && !ICAP_BUSY) begin
                    data_d  = rd_word;
                    state_d = ST_TURN_C;
                end else if (cnt_q == TIMEOUT_C) begin
                    data_d  = 16'h0000;
                    terr_d  = 1'b1;
                    state_d = ST_TURN_C;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_d = IDLE_WORD;
        ce_d   = 1'b1;
        wr_d   = 1'b1;
        case (state_q)
            ST_SYNC0:  begin word_d = SYNC_W1;        ce_d = 1'b0; wr_d = 1'b0; end
            ST_SYNC1:  begin word_d = SYNC_W2;        ce_d = 1'b0; wr_d = 1'b0; end
            ST_RDHDR:  begin word_d = rd_hdr(addr_q); ce_d = 1'b0; wr_d = 1'b0; end
            ST_NOP0, ST_NOP1, ST_NOP2, ST_NOP3, ST_NOP4:
                       begin word_d = NOOP;           ce_d = 1'b0; wr_d = 1'b0; end
            ST_TURN_A, ST_TURN_D: wr_d = 1'b0;
            ST_RD:     ce_d = 1'b0;
            ST_DSY_H:  begin word_d = WR_CMD_HDR;     ce_d = 1'b0; wr_d = 1'b0; end
            ST_DSY_L:  begin word_d = CMD_DESYNC;     ce_d = 1'b0; wr_d = 1'b0; end
            default:   ;
        endcase
        done_d = (state_d == ST_FIN);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= 16'h0000;
            terr_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ce_q    <= 1'b1;
            wr_q    <= 1'b1;
            word_q  <= IDLE_WORD;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            terr_q  <= terr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ce_q    <= ce_d;
            wr_q    <= wr_d;
            word_q  <= word_d;
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = terr_q;
    assign DATA        = data_q;
    assign ICAP_CE     = ce_q;
    assign ICAP_WRITE  = wr_q;

endmodule

// File: doc/icap_reg_reader.md
Name: icap_reg_reader

Overview:
- Read-back counterpart of the multiboot writer. Reads one 16-bit Spartan-6 configuration register through ICAP, e.g. BOOTSTS, GENERAL1/2 or STAT, so the core can see how it booted and from which SPI address.
- Runs this sequence: sync, NOOP, Type-1 read header, NOOPs, switch to read, capture, switch back, DESYNC.
- ICAP pins are exposed as ports rather than instantiating the primitive. The top level owns the single ICAP_SPARTAN6 and muxes it with the multiboot writer.

Parameters:
RD_LAT, 3, minimum number of registered read-mode cycles (ICAP_CE=0, ICAP_WRITE=1) before ICAP_O may be captured.
TIMEOUT, 255, maximum number of RD cycles spent waiting for ICAP_BUSY=0 before aborting; counter width is clog2(TIMEOUT+1).

Ports:
CLK  in  1  single clock, shared with the ICAP primitive.
RST_N  in  1  reset, synchronous, active-low.
START  in  1  one-cycle request; sampled only in IDLE.
REG_ADDR  in  6  configuration register address; latched on an accepted START.
BUSY  out  1  high from the cycle after an accepted START until DONE.
DONE  out  1  one-cycle pulse when the transaction completes (data valid or timeout).
TIMEOUT_ERR  out  1  valid with DONE; 1 if the read timed out; held until the next START.
DATA  out  16  register value, un-reversed; updated only at capture or timeout; holds between transactions.
ICAP_CE  out  1  to primitive CE (active-low).
ICAP_WRITE  out  1  to primitive WRITE (0 = write, 1 = read).
ICAP_I  out  16  to primitive I; bit-reversed within each byte.
ICAP_O  in  16  from primitive O; bit-reversed within each byte.
ICAP_BUSY  in  1  from primitive BUSY.

Behaviour:
- Reset (RST_N=0 at an edge) gives: state IDLE, ICAP_CE=1, ICAP_WRITE=1, ICAP_I=FFFF, BUSY=0, DONE=0, TIMEOUT_ERR=0, DATA=0000.
- Reset takes effect mid-transaction at the same edge. No DONE is generated, and no desync is attempted.
- Structure: a combinational next-state/word decode feeds one output register stage. ICAP_CE, ICAP_WRITE and ICAP_I therefore lag the state by exactly 1 cycle.
- Each state lasts 1 cycle unless noted. Listed per state: emitted word, CE/WRITE.
  - IDLE: FFFF, CE=1, WR=1. On START: latch REG_ADDR, clear TIMEOUT_ERR, go to SYNC0.
  - SYNC0: AA99, CE=0, WR=0.
  - SYNC1: 5566, CE=0, WR=0.
  - NOP0: 2000, CE=0, WR=0.
  - RDHDR: 2801 | (addr<<5), CE=0, WR=0. This is a Type-1 read of 1 word.
  - NOP1: 2000, CE=0, WR=0.
  - NOP2: 2000, CE=0, WR=0.
  - TURN_A: CE=1, WR=0.
  - TURN_B: CE=1, WR=1.
  - RD: CE=0, WR=1. Cycle counter starts at 0 on entry.
    - Capture when counter ≥ RD_LAT and ICAP_BUSY=0: DATA ← unreverse(ICAP_O), go to TURN_C.
    - Timeout when counter reaches TIMEOUT without a capture: DATA ← 0000, TIMEOUT_ERR ← 1, go to TURN_C.
    - A capture at the same cycle the counter reaches TIMEOUT wins over the timeout.
  - TURN_C: CE=1, WR=1.
  - TURN_D: CE=1, WR=0.
  - DSY_H: 30A1, CE=0, WR=0. Write to the CMD register.
  - DSY_L: 000D, CE=0, WR=0. DESYNC command.
  - NOP3: 2000, CE=0, WR=0.
  - NOP4: 2000, CE=0, WR=0.
  - FIN: FFFF, CE=1, WR=1. DONE=1 for this cycle only; go to IDLE.
- ICAP_I word order is fixed; only RDHDR depends on the latched address.
- The DESYNC sequence is always sent, including on timeout.
- Handshake and latency:
  - START outside IDLE is ignored.
  - REG_ADDR changes after acceptance have no effect.
  - Minimum latency from START to DONE is 16+RD_LAT cycles.
- Byte-wise bit reversal:
  - out[7:0] = rev(in[7:0]) and out[15:8] = rev(in[15:8]).
  - Applied to ICAP_I on the way out and to ICAP_O on capture.

Decomposition:
- Shared package icap_pkg holds:
  - Words: SYNC_W1 AA99, SYNC_W2 5566, NOOP 2000, WR_CMD_HDR 30A1, CMD_DESYNC 000D, CMD_REBOOT 000E, RD_HDR_BASE 2801.
  - Register addresses: STAT 08, IDCODE 0E, GENERAL1–5 13–17, MODE 18, BOOTSTS 20.
  - The reader state enumeration.
- The multiboot writer is migrated to the same package.
- One sub-module, icap_bitswap: combinational 16-bit byte-wise reversal, instanced on the I and O paths. The ICAP mux lives at top level and is out of scope for this block.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles → ICAP_CE=1, ICAP_WRITE=1, ICAP_I=FFFF, BUSY=0, DONE=0, DATA=0000.
- START with REG_ADDR=20 → starting 1 cycle after SYNC0, ICAP_I carries 5599, AA66, 0400, 3480, 0400, 0400 on consecutive cycles, with CE=0/WR=0. These are the raw reversed values of AA99, 5566, 2000, 2C01, 2000, 2000.
- Bench ICAP model drives ICAP_O=48 2C (reversed 1234) and BUSY=0 from the 2nd read cycle → DATA=1234, TIMEOUT_ERR=0, then desync words 30A1, 000D (reversed 0C85, 00B0). DONE pulses exactly once, at START+16+RD_LAT.
- ICAP_BUSY held at 1 → after TIMEOUT RD cycles: TIMEOUT_ERR=1, DATA=0000, desync still emitted, DONE pulses once.
- A second START plus REG_ADDR=13 while BUSY=1 → ignored; the header remains 2C01. A new START after DONE → header 2A61.
- RST_N=0 during RD → next cycle shows the idle outputs, BUSY=0, no DONE; the following START runs a full sequence correctly.
